// File: rtl/fib_pkg.sv
// Shared types and widths for the FIB lookup arbiter.
// Holds the FSM state encoding and the requester id type.
package fib_pkg;

   localparam int PREFIX_W = 64;
   localparam int LEN_W    = 6;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   typedef enum logic {
      PIT  = 1'b0,
      DATA = 1'b1
   } req_id_t;

   function automatic logic [1:0] id_onehot(input req_id_t id);
      return (id == DATA) ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/fib_lookup_arbiter_rr.sv
// Two-way round-robin selector between PIT and data-path requests.
// The pointer only breaks ties; a lone request always wins.
module fib_rr_arbiter
   import fib_pkg::*;
(
   input  logic       req_pit,
   input  logic       req_data,
   input  req_id_t    ptr,
   output logic [1:0] win
);

   // one-hot winner, bit 0 = PIT, bit 1 = DATA
   always_comb begin
      win = 2'b00;
      case ({req_data, req_pit})
         2'b01:   win = 2'b01;
         2'b10:   win = 2'b10;
         2'b11:   win = id_onehot(ptr);
         default: win = 2'b00;
      endcase
   end

endmodule

// File: rtl/fib_lookup_arbiter.sv
// Arbitrates PIT and data-path prefix lookups onto a single FIB port.
// Build option: define FIB_ARB_TIMEOUT_EN to enable the WAIT watchdog.
module fib_lookup_arbiter #(
   parameter int PREFIX_W       = fib_pkg::PREFIX_W,
   parameter int LEN_W          = fib_pkg::LEN_W,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                pit_req,
   input  logic [PREFIX_W-1:0] pit_prefix,
   input  logic [LEN_W-1:0]    pit_len,
   output logic                pit_gnt,
   output logic                pit_done,
   input  logic                data_req,
   input  logic [PREFIX_W-1:0] data_prefix,
   input  logic [LEN_W-1:0]    data_len,
   output logic                data_gnt,
   output logic                data_done,
   output logic                fib_start,
   output logic [PREFIX_W-1:0] fib_prefix,
   output logic [LEN_W-1:0]    fib_len,
   input  logic                fib_valid,
   input  logic                fib_hit,
   input  logic [LEN_W-1:0]    fib_match_len,
   output logic                res_hit,
   output logic [LEN_W-1:0]    res_match_len,
   output logic                timeout
);
   import fib_pkg::*;

   state_t              state;
   state_t              state_nxt;
   req_id_t             owner;
   req_id_t             ptr;
   req_id_t             sel_id;
   logic [1:0]          win;
   logic [1:0]          own_oh;
   logic [PREFIX_W-1:0] prefix_q;
   logic [LEN_W-1:0]    len_q;
   logic [PREFIX_W-1:0] sel_prefix;
   logic [LEN_W-1:0]    sel_len;
   logic                expire;
   logic [1:0]          gnt_d;
   logic [1:0]          done_d;
   logic                start_d;
   logic                hit_d;
   logic [LEN_W-1:0]    mlen_d;

   fib_rr_arbiter u_rr (
      .req_pit  (pit_req),
      .req_data (data_req),
      .ptr      (ptr),
      .win      (win)
   );

   assign own_oh     = id_onehot(owner);
   assign fib_prefix = prefix_q;
   assign fib_len    = len_q;

   // steer the winning requester's operands
   always_comb begin
      sel_id     = PIT;
      sel_prefix = '0;
      sel_len    = '0;
      unique case (1'b1)
         win[0]: begin
            sel_id     = PIT;
            sel_prefix = pit_prefix;
            sel_len    = pit_len;
         end
         win[1]: begin
            sel_id     = DATA;
            sel_prefix = data_prefix;
            sel_len    = data_len;
         end
         default: ;
      endcase
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // FSM next-state logic
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:  if (|win) state_nxt = ISSUE;
         ISSUE: state_nxt = (len_q != '0) ? WAIT : RESP;
         WAIT:  if (fib_valid || expire) state_nxt = RESP;
         RESP:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // next values of the registered pulses and result
   always_comb begin
      gnt_d   = 2'b00;
      done_d  = 2'b00;
      start_d = 1'b0;
      hit_d   = 1'b0;
      mlen_d  = '0;
      unique case (state)
         IDLE: begin
            gnt_d   = win;
            start_d = (|win) && (sel_len != '0);
         end
         ISSUE: begin
            if (len_q == '0) done_d = own_oh;
         end
         WAIT: begin
            if (fib_valid) begin
               done_d = own_oh;
               hit_d  = fib_hit;
               mlen_d = fib_match_len;
            end else if (expire) begin
               done_d = own_oh;
            end
         end
         default: ;
      endcase
   end

   // output registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         pit_gnt       <= 1'b0;
         data_gnt      <= 1'b0;
         pit_done      <= 1'b0;
         data_done     <= 1'b0;
         fib_start     <= 1'b0;
         res_hit       <= 1'b0;
         res_match_len <= '0;
      end else begin
         pit_gnt       <= gnt_d[0];
         data_gnt      <= gnt_d[1];
         pit_done      <= done_d[0];
         data_done     <= done_d[1];
         fib_start     <= start_d;
         res_hit       <= hit_d;
         res_match_len <= mlen_d;
      end
   end

   // transaction owner, operands and round-robin pointer
   always_ff @(posedge clk) begin
      if (!rst) begin
         owner    <= PIT;
         ptr      <= PIT;
         prefix_q <= '0;
         len_q    <= '0;
      end else begin
         if (state == IDLE && (|win)) begin
            owner    <= sel_id;
            prefix_q <= sel_prefix;
            len_q    <= sel_len;
         end
         if (state == RESP) begin
            ptr      <= (owner == PIT) ? DATA : PIT;
            prefix_q <= '0;
            len_q    <= '0;
         end
      end
   end

`ifdef FIB_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] wd_cnt;

   assign expire = (state == WAIT) && !fib_valid &&
                   (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   // count WAIT cycles spent without a FIB answer
   always_ff @(posedge clk) begin
      if (!rst || state != WAIT) wd_cnt <= '0;
      else if (!fib_valid)       wd_cnt <= wd_cnt + 1'b1;
   end

   // watchdog pulse coincides with the done pulse
   always_ff @(posedge clk) begin
      if (!rst) timeout <= 1'b0;
      else      timeout <= expire;
   end
`else
   assign expire  = 1'b0;
   assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_fib_lookup_arbiter.sv
// Directed self-checking bench for fib_lookup_arbiter.
// Works in both the default and FIB_ARB_TIMEOUT_EN builds.
module tb_fib_lookup_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        pit_req = 1'b0;
   logic [63:0] pit_prefix = '0;
   logic [5:0]  pit_len = '0;
   logic        pit_gnt, pit_done;
   logic        data_req = 1'b0;
   logic [63:0] data_prefix = '0;
   logic [5:0]  data_len = '0;
   logic        data_gnt, data_done;
   logic        fib_start;
   logic [63:0] fib_prefix;
   logic [5:0]  fib_len;
   logic        fib_valid = 1'b0;
   logic        fib_hit = 1'b0;
   logic [5:0]  fib_match_len = '0;
   logic        res_hit;
   logic [5:0]  res_match_len;
   logic        timeout;

   int n_assert = 0;
   int n_fail   = 0;
   int data_act = 0;
   int start_cnt = 0;
   int excl_err = 0;

   fib_lookup_arbiter #(
      .PREFIX_W       (64),
      .LEN_W          (6),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .pit_req       (pit_req),
      .pit_prefix    (pit_prefix),
      .pit_len       (pit_len),
      .pit_gnt       (pit_gnt),
      .pit_done      (pit_done),
      .data_req      (data_req),
      .data_prefix   (data_prefix),
      .data_len      (data_len),
      .data_gnt      (data_gnt),
      .data_done     (data_done),
      .fib_start     (fib_start),
      .fib_prefix    (fib_prefix),
      .fib_len       (fib_len),
      .fib_valid     (fib_valid),
      .fib_hit       (fib_hit),
      .fib_match_len (fib_match_len),
      .res_hit       (res_hit),
      .res_match_len (res_match_len),
      .timeout       (timeout)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (data_gnt === 1'b1 || data_done === 1'b1) data_act++;
      if (fib_start === 1'b1) start_cnt++;
      if ((pit_gnt === 1'b1 && data_gnt === 1'b1) ||
          (pit_done === 1'b1 && data_done === 1'b1))
         excl_err++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_gnt(output int who);
      who = -1;
      for (int i = 0; i < 8 && who < 0; i++) begin
         tick();
         if (pit_gnt === 1'b1)       who = 0;
         else if (data_gnt === 1'b1) who = 1;
      end
   endtask

   initial begin
      int who;
      int s0;
      int bad;
      int exp_who[4];
      logic [5:0] exp_len[2];
      exp_who = '{0, 1, 0, 1};
      exp_len = '{6'd8, 6'd16};

      // reset state
      tick();
      tick();
      chk("rst_pit_gnt", pit_gnt, 0);
      chk("rst_data_gnt", data_gnt, 0);
      chk("rst_done", {pit_done, data_done}, 0);
      chk("rst_start", fib_start, 0);
      chk("rst_res", {res_hit, res_match_len}, 0);
      chk("rst_fib_prefix", fib_prefix, 0);
      chk("rst_fib_len", fib_len, 0);
      chk("rst_timeout", timeout, 0);
      rst = 1'b1;
      tick();

      // single PIT lookup with hit
      pit_req    = 1'b1;
      pit_prefix = 64'h0000FFFF0000FFFF;
      pit_len    = 6'd48;
      tick();
      chk("t1_pit_gnt", pit_gnt, 1);
      chk("t1_start", fib_start, 1);
      chk("t1_fib_prefix", fib_prefix, 64'h0000FFFF0000FFFF);
      chk("t1_fib_len", fib_len, 48);
      pit_req    = 1'b0;
      pit_prefix = 64'hDEAD_BEEF_DEAD_BEEF;
      pit_len    = 6'd3;
      tick();
      chk("t1_gnt_pulse", {pit_gnt, fib_start}, 0);
      chk("t1_prefix_held", fib_prefix, 64'h0000FFFF0000FFFF);
      fib_valid     = 1'b1;
      fib_hit       = 1'b1;
      fib_match_len = 6'd32;
      tick();
      fib_valid = 1'b0;
      fib_hit   = 1'b0;
      chk("t1_pit_done", pit_done, 1);
      chk("t1_res_hit", res_hit, 1);
      chk("t1_res_len", res_match_len, 32);
      tick();
      chk("t1_done_pulse", pit_done, 0);
      chk("t1_prefix_clr", fib_prefix, 0);
      chk("t1_no_data", data_act, 0);

      // zero-length data lookup bypasses the FIB
      s0          = start_cnt;
      data_req    = 1'b1;
      data_prefix = 64'h1234;
      data_len    = 6'd0;
      tick();
      chk("t2_data_gnt", data_gnt, 1);
      chk("t2_start", fib_start, 0);
      data_req = 1'b0;
      tick();
      chk("t2_data_done", data_done, 1);
      chk("t2_res", {res_hit, res_match_len}, 0);
      tick();
      chk("t2_start_cnt", start_cnt, s0);
      chk("t2_done_pulse", data_done, 0);

      // round-robin with both requests held from reset
      rst = 1'b0;
      tick();
      pit_prefix  = 64'hAAAA;
      pit_len     = 6'd8;
      data_prefix = 64'hBBBB;
      data_len    = 6'd16;
      pit_req     = 1'b1;
      data_req    = 1'b1;
      rst         = 1'b1;
      for (int t = 0; t < 4; t++) begin
         wait_gnt(who);
         chk("t3_rr_order", who, exp_who[t]);
         if (who >= 0) chk("t3_fib_len", fib_len, exp_len[who]);
         tick();
         fib_valid     = 1'b1;
         fib_match_len = 6'd5;
         tick();
         fib_valid = 1'b0;
         if (who == 1) chk("t3_done", {data_done, pit_done}, 2'b10);
         else          chk("t3_done", {data_done, pit_done}, 2'b01);
         chk("t3_res_len", res_match_len, 5);
         tick();
      end
      pit_req  = 1'b0;
      data_req = 1'b0;
      tick();
      tick();

      // no FIB answer: watchdog or indefinite WAIT
      rst = 1'b0;
      tick();
      rst        = 1'b1;
      pit_req    = 1'b1;
      pit_prefix = 64'h77;
      pit_len    = 6'd4;
      tick();
      chk("t4_pit_gnt", pit_gnt, 1);
      pit_req = 1'b0;
      bad = 0;
`ifdef FIB_ARB_TIMEOUT_EN
      for (int i = 0; i < 8; i++) begin
         tick();
         if (pit_done !== 1'b0 || timeout !== 1'b0) bad++;
      end
      chk("t4_early_done", bad, 0);
      tick();
      chk("t4_to_done", pit_done, 1);
      chk("t4_timeout", timeout, 1);
      chk("t4_res_hit", res_hit, 0);
      tick();
      chk("t4_to_pulse", {timeout, pit_done}, 0);
`else
      for (int i = 0; i < 20; i++) begin
         tick();
         if (pit_done !== 1'b0 || timeout !== 1'b0) bad++;
      end
      chk("t4_stays_wait", bad, 0);
      chk("t4_prefix_held", fib_prefix, 64'h77);
`endif

      // reset during WAIT aborts, late fib_valid ignored
      rst = 1'b0;
      tick();
      rst        = 1'b1;
      pit_req    = 1'b1;
      pit_prefix = 64'h5555;
      pit_len    = 6'd12;
      tick();
      pit_req = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      chk("t5_rst_prefix", fib_prefix, 0);
      chk("t5_rst_res", {res_hit, res_match_len}, 0);
      fib_valid     = 1'b1;
      fib_hit       = 1'b1;
      fib_match_len = 6'd9;
      bad = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (pit_done !== 1'b0 || data_done !== 1'b0) bad++;
      end
      fib_valid = 1'b0;
      fib_hit   = 1'b0;
      chk("t5_no_done", bad, 0);
      pit_req    = 1'b1;
      pit_prefix = 64'hCAFE;
      pit_len    = 6'd20;
      tick();
      chk("t5_gnt", pit_gnt, 1);
      chk("t5_fib_prefix", fib_prefix, 64'hCAFE);
      pit_req = 1'b0;
      tick();
      fib_valid     = 1'b1;
      fib_hit       = 1'b1;
      fib_match_len = 6'd17;
      tick();
      fib_valid = 1'b0;
      chk("t5_done", pit_done, 1);
      chk("t5_res", {res_hit, res_match_len}, {1'b1, 6'd17});
      tick();

      chk("excl_pulses", excl_err, 0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
